// File: rtl/pipelined_control_unit.sv
// MIPS pipeline control: ID decode, ID/EX..MEM/WB bundle, hazards, forwarding.
// Option: define PCTL_ILLEGAL_TRAP_EN for the sticky illegal-opcode trap.
module pipelined_control_unit #(
  parameter int REG_W    = 5,
  parameter int ALUOP_W  = 4,
  parameter int LINK_REG = 31
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         FuncCode,
  input  logic [REG_W-1:0]   IdRs,
  input  logic [REG_W-1:0]   IdRt,
  input  logic [REG_W-1:0]   IdRd,
  input  logic               BranchTaken,
  input  logic               StallIn,
  output logic               PcWrite,
  output logic               IfIdWrite,
  output logic               IfIdFlush,
  output logic               IdSignExtend,
  output logic               IdJump,
  output logic               IdJal,
  output logic               IdIllegal,
  output logic [ALUOP_W-1:0] ExALUOp,
  output logic [1:0]         ExBranch,
  output logic               ExJr,
  output logic [REG_W-1:0]   ExDest,
  output logic [1:0]         ForwardA,
  output logic [1:0]         ForwardB,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               WbRegWrite,
  output logic               WbMemToReg,
  output logic [REG_W-1:0]   WbDest,
  output logic               Trap
);

  typedef struct packed {
    logic [ALUOP_W-1:0] aluOp;
    logic [1:0]         branch;
    logic               jr;
    logic               regWrite;
    logic               memRead;
    logic               memWrite;
    logic               memToReg;
    logic [REG_W-1:0]   dest;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
  } idEx_t;

  typedef struct packed {
    logic             regWrite;
    logic             memRead;
    logic             memWrite;
    logic             memToReg;
    logic [REG_W-1:0] dest;
  } exMem_t;

  typedef struct packed {
    logic             regWrite;
    logic             memToReg;
    logic [REG_W-1:0] dest;
  } memWb_t;

  idEx_t            idB;
  idEx_t            idEx;
  exMem_t           exMem;
  memWb_t           memWb;
  logic [3:0]       aluCode;
  logic [REG_W-1:0] rawDest;
  logic             rawWrite;
  logic             readsRt;
  logic             loadUse;
  logic             bubble;
  logic             hold;

`ifdef PCTL_ILLEGAL_TRAP_EN
  logic trapQ;
  logic trapSet;
`endif

  // Decode the ID instruction into its control bundle
  always_comb begin
    aluCode      = '0;
    rawDest      = '0;
    rawWrite     = 1'b0;
    readsRt      = 1'b0;
    IdSignExtend = 1'b0;
    IdJump       = 1'b0;
    IdJal        = 1'b0;
    IdIllegal    = 1'b0;
    idB          = '0;
    unique case (Opcode)
      6'h00: begin
        aluCode  = 4'b1111;
        rawWrite = 1'b1;
        rawDest  = IdRd;
        readsRt  = 1'b1;
        idB.jr   = (FuncCode == 6'h08);
      end
      6'h23: begin
        aluCode      = 4'b0010;
        IdSignExtend = 1'b1;
        rawWrite     = 1'b1;
        rawDest      = IdRt;
        idB.memRead  = 1'b1;
        idB.memToReg = 1'b1;
      end
      6'h2B: begin
        aluCode      = 4'b0010;
        IdSignExtend = 1'b1;
        readsRt      = 1'b1;
        idB.memWrite = 1'b1;
      end
      6'h04: begin
        aluCode      = 4'b0110;
        IdSignExtend = 1'b1;
        readsRt      = 1'b1;
        idB.branch   = 2'b01;
      end
      6'h05: begin
        aluCode      = 4'b0110;
        IdSignExtend = 1'b1;
        readsRt      = 1'b1;
        idB.branch   = 2'b11;
      end
      6'h02: IdJump = 1'b1;
      6'h03: begin
        IdJump   = 1'b1;
        IdJal    = 1'b1;
        rawWrite = 1'b1;
        rawDest  = REG_W'(LINK_REG);
      end
      6'h0D: begin aluCode = 4'b0001; rawWrite = 1'b1; rawDest = IdRt; end
      6'h09: begin aluCode = 4'b1000; rawWrite = 1'b1; rawDest = IdRt; end
      6'h0C: begin aluCode = 4'b0000; rawWrite = 1'b1; rawDest = IdRt; end
      6'h0F: begin aluCode = 4'b1110; rawWrite = 1'b1; rawDest = IdRt; end
      6'h0E: begin aluCode = 4'b1010; rawWrite = 1'b1; rawDest = IdRt; end
      6'h08: begin
        aluCode = 4'b0010; IdSignExtend = 1'b1;
        rawWrite = 1'b1; rawDest = IdRt;
      end
      6'h0A: begin
        aluCode = 4'b0111; IdSignExtend = 1'b1;
        rawWrite = 1'b1; rawDest = IdRt;
      end
      6'h0B: begin
        aluCode = 4'b1011; IdSignExtend = 1'b1;
        rawWrite = 1'b1; rawDest = IdRt;
      end
      default: IdIllegal = 1'b1;
    endcase
    idB.aluOp    = ALUOP_W'(aluCode);
    idB.dest     = rawDest;
    idB.regWrite = rawWrite && (rawDest != '0);
    if (!IdIllegal) begin
      idB.rs = IdRs;
      idB.rt = IdRt;
    end
  end

  assign loadUse = idEx.memRead && (idEx.dest != '0) &&
    ((idEx.dest == IdRs) || (readsRt && (idEx.dest == IdRt)));

  // Prioritised PC / IF-ID control and EX bubble insertion
  always_comb begin
    PcWrite   = 1'b1;
    IfIdWrite = 1'b1;
    IfIdFlush = 1'b0;
    bubble    = 1'b0;
    hold      = 1'b0;
`ifdef PCTL_ILLEGAL_TRAP_EN
    trapSet   = 1'b0;
`endif
    if (Reset) begin
      PcWrite   = 1'b0;
      IfIdWrite = 1'b0;
      IfIdFlush = 1'b1;
    end else if (StallIn) begin
      PcWrite   = 1'b0;
      IfIdWrite = 1'b0;
      hold      = 1'b1;
    end else if (BranchTaken) begin
      IfIdFlush = 1'b1;
      bubble    = 1'b1;
    end else if (loadUse) begin
      PcWrite   = 1'b0;
      IfIdWrite = 1'b0;
      bubble    = 1'b1;
    end else begin
      IfIdFlush = IdJump;
`ifdef PCTL_ILLEGAL_TRAP_EN
      if (IdIllegal && !trapQ) begin
        trapSet   = 1'b1;
        IfIdFlush = 1'b1;
        PcWrite   = 1'b0;
      end
`endif
    end
`ifdef PCTL_ILLEGAL_TRAP_EN
    if (trapQ) begin
      PcWrite = 1'b0;
      bubble  = 1'b1;
    end
`endif
  end

  // Stage registers: clear on reset, freeze on external stall
  always_ff @(posedge CLK) begin
    if (Reset) begin
      idEx  <= '0;
      exMem <= '0;
      memWb <= '0;
    end else if (!hold) begin
      idEx           <= bubble ? '0 : idB;
      exMem.regWrite <= idEx.regWrite;
      exMem.memRead  <= idEx.memRead;
      exMem.memWrite <= idEx.memWrite;
      exMem.memToReg <= idEx.memToReg;
      exMem.dest     <= idEx.dest;
      memWb.regWrite <= exMem.regWrite;
      memWb.memToReg <= exMem.memToReg;
      memWb.dest     <= exMem.dest;
    end
  end

`ifdef PCTL_ILLEGAL_TRAP_EN
  // Sticky trap, cleared only by reset
  always_ff @(posedge CLK) begin
    if (Reset) trapQ <= 1'b0;
    else if (trapSet) trapQ <= 1'b1;
  end
  assign Trap = trapQ;
`else
  assign Trap = 1'b0;
`endif

  // EX operand forwarding, MEM result preferred over WB
  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (exMem.regWrite && (exMem.dest == idEx.rs)) ForwardA = 2'b10;
    else if (memWb.regWrite && (memWb.dest == idEx.rs)) ForwardA = 2'b01;
    if (exMem.regWrite && (exMem.dest == idEx.rt)) ForwardB = 2'b10;
    else if (memWb.regWrite && (memWb.dest == idEx.rt)) ForwardB = 2'b01;
  end

  assign ExALUOp    = idEx.aluOp;
  assign ExBranch   = idEx.branch;
  assign ExJr       = idEx.jr;
  assign ExDest     = idEx.dest;
  assign MemRead    = exMem.memRead;
  assign MemWrite   = exMem.memWrite;
  assign WbRegWrite = memWb.regWrite;
  assign WbMemToReg = memWb.memToReg;
  assign WbDest     = memWb.dest;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: instruction-level pipeline model,
// per-cycle compare plus hand-computed pins.
module tb_pipelined_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] Opcode, FuncCode;
  logic [4:0] IdRs, IdRt, IdRd;
  logic       BranchTaken, StallIn;
  logic       PcWrite, IfIdWrite, IfIdFlush;
  logic       IdSignExtend, IdJump, IdJal, IdIllegal;
  logic [3:0] ExALUOp;
  logic [1:0] ExBranch;
  logic       ExJr;
  logic [4:0] ExDest;
  logic [1:0] ForwardA, ForwardB;
  logic       MemRead, MemWrite;
  logic       WbRegWrite, WbMemToReg;
  logic [4:0] WbDest;
  logic       Trap;

  always #5 CLK = ~CLK;

  pipelined_control_unit dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .FuncCode(FuncCode),
    .IdRs(IdRs), .IdRt(IdRt), .IdRd(IdRd),
    .BranchTaken(BranchTaken), .StallIn(StallIn),
    .PcWrite(PcWrite), .IfIdWrite(IfIdWrite), .IfIdFlush(IfIdFlush),
    .IdSignExtend(IdSignExtend), .IdJump(IdJump), .IdJal(IdJal),
    .IdIllegal(IdIllegal), .ExALUOp(ExALUOp), .ExBranch(ExBranch),
    .ExJr(ExJr), .ExDest(ExDest), .ForwardA(ForwardA),
    .ForwardB(ForwardB), .MemRead(MemRead), .MemWrite(MemWrite),
    .WbRegWrite(WbRegWrite), .WbMemToReg(WbMemToReg),
    .WbDest(WbDest), .Trap(Trap)
  );

  typedef struct packed {
    logic [3:0] alu;
    logic [1:0] br;
    logic jr, rw, mr, mw, m2r;
    logic [4:0] dest, rs, rt;
  } rec_t;

  typedef struct packed {
    rec_t r;
    logic se, jmp, jal, ill, rdRt;
  } dec_t;

  int   nVec, nBad;
  logic chkEn = 1'b0;

  // model state: the instruction occupying each stage
  rec_t mEx = '0, mMem = '0, mWb = '0;
  logic mTrap = 1'b0;

  dec_t       eD;
  logic       lu, ePcw, eIfw, eFl, eBub, eHold, eTset;
  logic [1:0] eFa, eFb;

  function automatic dec_t dec(logic [5:0] op, logic [5:0] fn,
                               logic [4:0] rs, logic [4:0] rt,
                               logic [4:0] rd);
    dec_t d;
    logic w;
    d = '0;
    w = 1'b0;
    case (op)
      6'h00: begin
        d.r.alu = 4'hF; w = 1; d.r.dest = rd; d.rdRt = 1;
        d.r.jr = (fn == 6'h08);
      end
      6'h23: begin
        d.r.alu = 4'h2; d.se = 1; w = 1; d.r.dest = rt;
        d.r.mr = 1; d.r.m2r = 1;
      end
      6'h2B: begin d.r.alu = 4'h2; d.se = 1; d.rdRt = 1; d.r.mw = 1; end
      6'h04: begin d.r.alu = 4'h6; d.se = 1; d.rdRt = 1; d.r.br = 2'b01; end
      6'h05: begin d.r.alu = 4'h6; d.se = 1; d.rdRt = 1; d.r.br = 2'b11; end
      6'h02: d.jmp = 1;
      6'h03: begin d.jmp = 1; d.jal = 1; w = 1; d.r.dest = 5'd31; end
      6'h0D: begin d.r.alu = 4'h1; w = 1; d.r.dest = rt; end
      6'h08: begin d.r.alu = 4'h2; d.se = 1; w = 1; d.r.dest = rt; end
      6'h09: begin d.r.alu = 4'h8; w = 1; d.r.dest = rt; end
      6'h0C: begin d.r.alu = 4'h0; w = 1; d.r.dest = rt; end
      6'h0F: begin d.r.alu = 4'hE; w = 1; d.r.dest = rt; end
      6'h0A: begin d.r.alu = 4'h7; d.se = 1; w = 1; d.r.dest = rt; end
      6'h0B: begin d.r.alu = 4'hB; d.se = 1; w = 1; d.r.dest = rt; end
      6'h0E: begin d.r.alu = 4'hA; w = 1; d.r.dest = rt; end
      default: d.ill = 1;
    endcase
    d.r.rw = w && (d.r.dest != 5'd0);
    if (!d.ill) begin
      d.r.rs = rs;
      d.r.rt = rt;
    end
    return d;
  endfunction

  function automatic logic [1:0] fwd(logic [4:0] s, rec_t m, rec_t w);
    if (m.rw && m.dest == s) return 2'd2;
    if (w.rw && w.dest == s) return 2'd1;
    return 2'd0;
  endfunction

  // model: what the control outputs must be this cycle
  always_comb begin
    eD = dec(Opcode, FuncCode, IdRs, IdRt, IdRd);
    lu = mEx.mr && mEx.dest != 0 &&
         (mEx.dest == IdRs || (eD.rdRt && mEx.dest == IdRt));
    ePcw = 1; eIfw = 1; eFl = 0; eBub = 0; eHold = 0; eTset = 0;
    if (Reset) begin
      ePcw = 0; eIfw = 0; eFl = 1;
    end else if (StallIn) begin
      ePcw = 0; eIfw = 0; eHold = 1;
    end else if (BranchTaken) begin
      eFl = 1; eBub = 1;
    end else if (lu) begin
      ePcw = 0; eIfw = 0; eBub = 1;
    end else begin
      eFl = eD.jmp;
`ifdef PCTL_ILLEGAL_TRAP_EN
      if (eD.ill && !mTrap) begin eTset = 1; eFl = 1; ePcw = 0; end
`endif
    end
`ifdef PCTL_ILLEGAL_TRAP_EN
    if (mTrap) begin ePcw = 0; eBub = 1; end
`endif
    eFa = fwd(mEx.rs, mMem, mWb);
    eFb = fwd(mEx.rt, mMem, mWb);
  end

  // model: move instructions one stage per clock
  always @(posedge CLK) begin
    if (Reset) begin
      mEx = '0; mMem = '0; mWb = '0; mTrap = 0;
    end else if (!eHold) begin
      mWb  = mMem;
      mMem = mEx;
      mEx  = eBub ? '0 : eD.r;
      if (eTset) mTrap = 1;
    end
  end

  task automatic chk(string n, logic [7:0] a, logic [7:0] e);
    nVec++;
    if (a !== e) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge CLK) begin
    if (chkEn) begin
      chk("PcWrite", 8'(PcWrite), 8'(ePcw));
      chk("IfIdWrite", 8'(IfIdWrite), 8'(eIfw));
      chk("IfIdFlush", 8'(IfIdFlush), 8'(eFl));
      chk("IdSignExtend", 8'(IdSignExtend), 8'(eD.se));
      chk("IdJump", 8'(IdJump), 8'(eD.jmp));
      chk("IdJal", 8'(IdJal), 8'(eD.jal));
      chk("IdIllegal", 8'(IdIllegal), 8'(eD.ill));
      chk("ExALUOp", 8'(ExALUOp), 8'(mEx.alu));
      chk("ExBranch", 8'(ExBranch), 8'(mEx.br));
      chk("ExJr", 8'(ExJr), 8'(mEx.jr));
      chk("ExDest", 8'(ExDest), 8'(mEx.dest));
      chk("ForwardA", 8'(ForwardA), 8'(eFa));
      chk("ForwardB", 8'(ForwardB), 8'(eFb));
      chk("MemRead", 8'(MemRead), 8'(mMem.mr));
      chk("MemWrite", 8'(MemWrite), 8'(mMem.mw));
      chk("WbRegWrite", 8'(WbRegWrite), 8'(mWb.rw));
      chk("WbMemToReg", 8'(WbMemToReg), 8'(mWb.m2r));
      chk("WbDest", 8'(WbDest), 8'(mWb.dest));
      chk("Trap", 8'(Trap), 8'(mTrap));
    end
  end

  task automatic step(int op, int fn, int rs, int rt, int rd,
                      int bt, int st, int rst);
    @(posedge CLK);
    #1;
    Opcode = 6'(op); FuncCode = 6'(fn);
    IdRs = 5'(rs); IdRt = 5'(rt); IdRd = 5'(rd);
    BranchTaken = 1'(bt); StallIn = 1'(st); Reset = 1'(rst);
    @(negedge CLK);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [7:0] sweep [10];

  initial begin
    nVec = 0; nBad = 0;
    Reset = 1; Opcode = 0; FuncCode = 0;
    IdRs = 0; IdRt = 0; IdRd = 0; BranchTaken = 0; StallIn = 0;
    @(posedge CLK);
    #1;
    chkEn = 1;

    // reset
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst.PcWrite", 8'(PcWrite), 8'd0);
    chk("rst.IfIdWrite", 8'(IfIdWrite), 8'd0);
    chk("rst.IfIdFlush", 8'(IfIdFlush), 8'd1);
    chk("rst.ExALUOp", 8'(ExALUOp), 8'd0);
    chk("rst.WbRegWrite", 8'(WbRegWrite), 8'd0);
    chk("rst.Trap", 8'(Trap), 8'd0);

    // addi $2 ; addi $2 ; add $3,$2,$2
    step('h08, 0, 0, 2, 0, 0, 0, 0);
    step('h08, 0, 0, 2, 0, 0, 0, 0);
    step('h00, 'h20, 2, 2, 3, 0, 0, 0);
    nop();
    chk("add.ForwardA", 8'(ForwardA), 8'd2);
    chk("add.ForwardB", 8'(ForwardB), 8'd2);
    chk("add.ExALUOp", 8'(ExALUOp), 8'hF);
    chk("add.ExDest", 8'(ExDest), 8'd3);
    nop();
    chk("addi.WbRegWrite", 8'(WbRegWrite), 8'd1);
    chk("addi.WbDest", 8'(WbDest), 8'd2);

    // lw $5 ; sub $6,$5,$1 -> one stall cycle
    step('h23, 0, 0, 5, 0, 0, 0, 0);
    step('h00, 'h22, 5, 1, 6, 0, 0, 0);
    chk("lu.PcWrite", 8'(PcWrite), 8'd0);
    chk("lu.IfIdWrite", 8'(IfIdWrite), 8'd0);
    step('h00, 'h22, 5, 1, 6, 0, 0, 0);
    chk("lu.bubbleAlu", 8'(ExALUOp), 8'd0);
    chk("lu.bubbleDest", 8'(ExDest), 8'd0);
    chk("lu.PcResume", 8'(PcWrite), 8'd1);
    nop();
    chk("lu.ForwardA", 8'(ForwardA), 8'd1);

    // taken beq squashes the instruction behind it
    step('h04, 0, 1, 2, 0, 0, 0, 0);
    step('h08, 0, 0, 7, 0, 1, 0, 0);
    chk("beq.ExBranch", 8'(ExBranch), 8'd1);
    chk("beq.IfIdFlush", 8'(IfIdFlush), 8'd1);
    chk("beq.PcWrite", 8'(PcWrite), 8'd1);
    nop();
    chk("beq.nextBranch", 8'(ExBranch), 8'd0);
    chk("beq.nextDest", 8'(ExDest), 8'd0);
    step('h05, 0, 3, 4, 0, 0, 0, 0);
    nop();
    chk("bne.ExBranch", 8'(ExBranch), 8'd3);

    // external stall for 3 cycles with lw in EX
    step('h23, 0, 0, 8, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step('h00, 'h20, 1, 1, 9, 0, 1, 0);
      chk("stall.ExDest", 8'(ExDest), 8'd8);
      chk("stall.PcWrite", 8'(PcWrite), 8'd0);
      chk("stall.IfIdFlush", 8'(IfIdFlush), 8'd0);
    end
    step('h00, 'h20, 1, 1, 9, 0, 0, 0);
    chk("stall.resumeEx", 8'(ExDest), 8'd8);
    nop();
    chk("stall.nextEx", 8'(ExDest), 8'd9);
    chk("stall.MemRead", 8'(MemRead), 8'd1);

    // jal writes the link register three cycles later
    step('h03, 0, 0, 0, 0, 0, 0, 0);
    chk("jal.IdJump", 8'(IdJump), 8'd1);
    chk("jal.IdJal", 8'(IdJal), 8'd1);
    chk("jal.IfIdFlush", 8'(IfIdFlush), 8'd1);
    nop(); nop(); nop();
    chk("jal.WbDest", 8'(WbDest), 8'd31);
    chk("jal.WbRegWrite", 8'(WbRegWrite), 8'd1);

    // write to $0 is suppressed
    step('h08, 0, 1, 0, 0, 0, 0, 0);
    nop(); nop(); nop();
    chk("r0.WbRegWrite", 8'(WbRegWrite), 8'd0);

    // remaining opcodes, jr and j
    sweep = '{8'h0D, 8'h09, 8'h0C, 8'h0F, 8'h0A,
              8'h0B, 8'h0E, 8'h2B, 8'h02, 8'h23};
    for (int i = 0; i < 10; i++)
      step(int'(sweep[i]), 0, 1, 10 + i, 20, 0, 0, 0);
    step('h00, 'h08, 31, 0, 0, 0, 0, 0);
    nop();
    chk("jr.ExJr", 8'(ExJr), 8'd1);
    nop(); nop();

    // reset arriving during an external stall
    step('h23, 0, 0, 12, 0, 0, 0, 0);
    step('h00, 'h20, 12, 0, 13, 0, 1, 0);
    step('h00, 'h20, 12, 0, 13, 0, 1, 1);
    chk("rstStall.IfIdFlush", 8'(IfIdFlush), 8'd1);
    nop();
    chk("rstStall.ExDest", 8'(ExDest), 8'd0);
    chk("rstStall.ExALUOp", 8'(ExALUOp), 8'd0);
    chk("rstStall.MemRead", 8'(MemRead), 8'd0);

    // illegal opcode 3F
    step('h3F, 0, 1, 2, 3, 0, 0, 0);
    chk("ill.IdIllegal", 8'(IdIllegal), 8'd1);
    step('h08, 0, 0, 4, 0, 0, 0, 0);
`ifdef PCTL_ILLEGAL_TRAP_EN
    chk("ill.Trap", 8'(Trap), 8'd1);
    chk("ill.PcWrite", 8'(PcWrite), 8'd0);
    nop();
    chk("ill.bubbleDest", 8'(ExDest), 8'd0);
`else
    chk("ill.Trap", 8'(Trap), 8'd0);
    chk("ill.PcWrite", 8'(PcWrite), 8'd1);
    nop();
    chk("ill.nextDest", 8'(ExDest), 8'd4);
`endif
    step(0, 0, 0, 0, 0, 0, 0, 1);
    nop();
    chk("ill.TrapCleared", 8'(Trap), 8'd0);
    nop();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Next-generation MIPS control block. It decodes the instruction in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers. It also contains the load-use hazard detector, the branch/jump flush logic and the EX-stage forwarding selects. It sits beside the datapath pipeline registers and replaces the purely combinational decoder.

Parameters:
REG_W, 5, register-specifier width
ALUOP_W, 4, ALU operation code width (encodings occupy the low 4 bits, zero-extended)
LINK_REG, 31, destination register for jal

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
Opcode  in  6  ID instruction opcode
FuncCode  in  6  ID instruction funct
IdRs, IdRt, IdRd  in  REG_W  ID register specifiers
BranchTaken  in  1  EX redirect: taken beq/bne or jr in EX
StallIn  in  1  external memory stall; freezes the pipeline
PcWrite, IfIdWrite, IfIdFlush  out  1  IF-stage controls
IdSignExtend, IdJump, IdJal, IdIllegal  out  1  combinational ID decode
ExALUOp  out  ALUOP_W; ExBranch  out  2; ExJr  out  1; ExDest  out  REG_W
ForwardA, ForwardB  out  2  EX operand selects
MemRead, MemWrite  out  1  MEM stage
WbRegWrite, WbMemToReg  out  1; WbDest  out  REG_W
Trap  out  1  sticky illegal-instruction flag (optional feature)

Behaviour:
- Decode (opcode hex → ALUOp, SignExt, RegWrite):
  - 00 R-type → 1111, 0, 1; Dest=Rd; Jr when funct=08.
  - 23 lw → 0010, 1, 1, plus MemRead and MemToReg.
  - 2B sw → 0010, 1, 0, plus MemWrite.
  - 04 beq → 0110, 1, 0, Branch=01. 05 bne → 0110, 1, 0, Branch=11.
  - 02 j → Jump. 03 jal → Jump, Jal, RegWrite, Dest=LINK_REG.
  - 0D ori→0001; 08 addi→0010 (SE); 09 addiu→1000; 0C andi→0000; 0F lui→1110; 0A slti→0111 (SE); 0B sltiu→1011 (SE); 0E xori→1010. All write Rt.
  - Any other opcode: IdIllegal=1, bundle = all-zero bubble.
- Destination register is resolved in ID. Dest=0 forces RegWrite=0 in the registered bundle.
- A latency of 1 cycle per stage: the ID bundle appears on Ex* one cycle later, Mem* two cycles later and Wb* three cycles later.
- Load-use stall: ExMemRead && ExDest!=0 && (ExDest==IdRs || (ExDest==IdRt && ID reads Rt)). R-type, sw, beq and bne read Rt.
  - Response: PcWrite=0, IfIdWrite=0, a bubble enters EX, and EX/MEM advances normally.
- BranchTaken: IfIdFlush=1 and a bubble enters EX. PcWrite=1 and IfIdWrite=1.
- IdJump with no stall and no BranchTaken: IfIdFlush=1. The jump itself proceeds to EX.
- StallIn: all stage registers hold, PcWrite=0, IfIdWrite=0, IfIdFlush=0.
- Priority: Reset > StallIn > BranchTaken > load-use > normal.
- Forwarding is combinational on the registered state:
  - ForwardA=10 if MemRegWrite && MemDest==ExRs.
  - Otherwise ForwardA=01 if WbRegWrite && WbDest==ExRs.
  - Otherwise ForwardA=00.
  - ForwardB uses the same rules with ExRt. The MEM stage wins when both match.
- Reset: all stage registers clear to a bubble (every registered output 0, ForwardA/B=00). During Reset: PcWrite=0, IfIdWrite=0, IfIdFlush=1, Trap=0. Reset in mid-stall discards all in-flight state.

Optional Feature:
PCTL_ILLEGAL_TRAP_EN
- Defined: an illegal opcode in ID that is not stalled or flushed sets Trap on the next edge. Trap is sticky until Reset. In the same cycle, IfIdFlush=1 and PcWrite=0. While Trap=1, PcWrite=0 and only bubbles enter EX; instructions already in flight drain.
- Undefined: Trap is tied to 0 and illegal opcodes pass through as bubbles.

Test Plan:
- Reset, then addi $2 (08), then add $3,$2,$2 back-to-back → at the add's EX cycle, ForwardA=10, ForwardB=10, ExALUOp=1111; WbRegWrite=1 and WbDest=2 one cycle later.
- lw $5 followed by sub using $5 → one cycle with PcWrite=0 and IfIdWrite=0; Ex* is a bubble the next cycle; afterwards ForwardA=01.
- beq in EX with BranchTaken=1 and StallIn=0 → IfIdFlush=1, next ExBranch=00, PcWrite=1.
- StallIn=1 for 3 cycles during lw, add → all Ex*/Mem*/Wb* outputs constant; the sequence resumes unchanged.
- jal (03) → IdJump=1, IfIdFlush=1; three cycles later WbDest=31 and WbRegWrite=1. Also: addi to $0 → WbRegWrite=0.
- Opcode 3F with the macro defined → Trap=1 from the next cycle onward and PcWrite=0; Reset clears it. Without the macro → Trap=0 and IdIllegal=1.
